ldpc_simd_alu: RTL and testbench

// Packed-SIMD fixed-point ALU for LDPC min-sum decoding; sits beside the scalar alu in the EX stage.

---
 rtl/ldpc_simd_alu_if.sv | 34 +++
 rtl/ldpc_simd_alu.sv | 163 ++++++++++++++++
 tb/tb_ldpc_simd_alu.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_simd_alu_if.sv
// Request/result bus of the LDPC packed-SIMD ALU: one valid/ready request channel
// and one valid/ready result channel carrying lanewise and check-node results.
interface ldpc_simd_alu_if #(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = 16
);
  localparam int DATA_W = LANE_W * NUM_LANES;

  logic              valid_i;
  logic              ready_o;
  logic [2:0]        op_i;
  logic              last_i;
  logic [DATA_W-1:0] operand_a_i;
  logic [DATA_W-1:0] operand_b_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] result_o;
  logic              cnu_o;
  logic [LANE_W-1:0] min1_o;
  logic [LANE_W-1:0] min2_o;
  logic [IDX_W-1:0]  min_idx_o;
  logic              sign_o;

  modport master (
    output valid_i, op_i, last_i, operand_a_i, operand_b_i, ready_i,
    input  ready_o, valid_o, result_o, cnu_o, min1_o, min2_o, min_idx_o, sign_o
  );

  modport slave (
    input  valid_i, op_i, last_i, operand_a_i, operand_b_i, ready_i,
    output ready_o, valid_o, result_o, cnu_o, min1_o, min2_o, min_idx_o, sign_o
  );
endinterface

// File: rtl/ldpc_simd_alu.sv
// Packed-SIMD saturating ALU for min-sum LDPC decoding with a multi-beat check-node
// reducer tracking min1, min2, argmin and sign parity; one registered output beat.
module ldpc_simd_alu #(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 8,
  parameter int IDX_W     = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  ldpc_simd_alu_if.slave    io
);
  localparam int DATA_W = LANE_W * NUM_LANES;
  localparam logic [LANE_W-1:0] MAXV = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] MINV = {1'b1, {(LANE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MAX, OP_MIN, OP_ADD, OP_SUB, OP_SCALE, OP_ABS, OP_CNU, OP_RSVD
  } op_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic [LANE_W-1:0] sat(input logic [LANE_W:0] s);
    if (s[LANE_W] != s[LANE_W-1]) return s[LANE_W] ? MINV : MAXV;
    return s[LANE_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] absSat(input logic [LANE_W-1:0] a);
    if (a == MINV) return MAXV;
    return a[LANE_W-1] ? (LANE_W'(0) - a) : a;
  endfunction

  state_t            state_q;
  logic              valid_q, cnu_q, sign_q;
  logic [DATA_W-1:0] result_q;
  logic [LANE_W-1:0] min1_q, min2_q;
  logic [IDX_W-1:0]  minIdx_q;
  logic [LANE_W-1:0] accMin1_q, accMin2_q;
  logic [IDX_W-1:0]  accIdx_q, accBeat_q;
  logic              accSign_q;

  logic [LANE_W-1:0] accMin1_d, accMin2_d;
  logic [IDX_W-1:0]  accIdx_d, laneIdx, beatBase;
  logic              accSign_d;
  logic [DATA_W-1:0] laneRes;
  logic [LANE_W-1:0] mag [NUM_LANES];
  op_t               opSel;
  logic              accept;

  assign opSel      = op_t'(io.op_i);
  assign io.ready_o = !valid_q || io.ready_i;
  assign accept     = io.valid_i && io.ready_o;

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    logic signed [LANE_W-1:0] a, b;
    logic [LANE_W:0]          sum, diff;
    logic [LANE_W-1:0]        r;

    assign a    = io.operand_a_i[k*LANE_W +: LANE_W];
    assign b    = io.operand_b_i[k*LANE_W +: LANE_W];
    assign sum  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    assign diff = {a[LANE_W-1], a} - {b[LANE_W-1], b};
    assign mag[k] = absSat(a);

    always_comb begin
      r = '0;
      case (opSel)
        OP_MAX:   r = (a > b) ? a : b;
        OP_MIN:   r = (a < b) ? a : b;
        OP_ADD:   r = sat(sum);
        OP_SUB:   r = sat(diff);
        OP_SCALE: r = a - (a >>> 2);
        OP_ABS:   r = mag[k];
        default:  r = '0;
      endcase
    end

    assign laneRes[k*LANE_W +: LANE_W] = r;
  end

  // Lanes merge in ascending index order, so an equal magnitude never displaces min1.
  always_comb begin
    accMin1_d = (state_q == IDLE) ? MAXV : accMin1_q;
    accMin2_d = (state_q == IDLE) ? MAXV : accMin2_q;
    accIdx_d  = (state_q == IDLE) ? '0 : accIdx_q;
    accSign_d = (state_q == IDLE) ? 1'b0 : accSign_q;
    beatBase  = accBeat_q * IDX_W'(NUM_LANES);
    laneIdx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      laneIdx = beatBase + IDX_W'(k);
      if (mag[k] < accMin1_d) begin
        accMin2_d = accMin1_d;
        accMin1_d = mag[k];
        accIdx_d  = laneIdx;
      end else if (mag[k] == accMin1_d) begin
        accMin2_d = accMin1_d;
      end else if (mag[k] < accMin2_d) begin
        accMin2_d = mag[k];
      end
      accSign_d = accSign_d ^ io.operand_a_i[k*LANE_W + LANE_W - 1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      result_q  <= '0;
      cnu_q     <= 1'b0;
      min1_q    <= '0;
      min2_q    <= '0;
      minIdx_q  <= '0;
      sign_q    <= 1'b0;
      accMin1_q <= MAXV;
      accMin2_q <= MAXV;
      accIdx_q  <= '0;
      accSign_q <= 1'b0;
      accBeat_q <= '0;
    end else if (accept && opSel == OP_CNU) begin
      if (io.last_i) begin
        state_q   <= IDLE;
        valid_q   <= 1'b1;
        result_q  <= '0;
        cnu_q     <= 1'b1;
        min1_q    <= accMin1_d;
        min2_q    <= accMin2_d;
        minIdx_q  <= accIdx_d;
        sign_q    <= accSign_d;
        accMin1_q <= MAXV;
        accMin2_q <= MAXV;
        accIdx_q  <= '0;
        accSign_q <= 1'b0;
        accBeat_q <= '0;
      end else begin
        // A non-last beat produces nothing, so any held result was just consumed.
        state_q   <= ACCUM;
        valid_q   <= 1'b0;
        accMin1_q <= accMin1_d;
        accMin2_q <= accMin2_d;
        accIdx_q  <= accIdx_d;
        accSign_q <= accSign_d;
        accBeat_q <= accBeat_q + 1'b1;
      end
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= laneRes;
      cnu_q    <= 1'b0;
      min1_q   <= '0;
      min2_q   <= '0;
      minIdx_q <= '0;
      sign_q   <= 1'b0;
    end else if (io.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign io.valid_o   = valid_q;
  assign io.result_o  = result_q;
  assign io.cnu_o     = cnu_q;
  assign io.min1_o    = min1_q;
  assign io.min2_o    = min2_q;
  assign io.min_idx_o = minIdx_q;
  assign io.sign_o    = sign_q;
endmodule

// File: tb/tb_ldpc_simd_alu.sv
// Directed bench for ldpc_simd_alu with four 8-bit lanes: lanewise ops, check-node
// reduction, output stall, interleaving and mid-accumulation reset.
module tb_ldpc_simd_alu;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = 16;

  localparam logic [2:0] OP_MAX = 3'd0, OP_MIN = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4, OP_ABS = 3'd5, OP_CNU = 3'd6, OP_RSVD = 3'd7;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  ldpc_simd_alu_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) bus ();

  ldpc_simd_alu #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Presents one beat for a single edge; the caller guarantees ready_o is high.
  task automatic send(input logic [2:0] op, input logic last, input logic [31:0] a,
                      input logic [31:0] b);
    bus.valid_i     = 1'b1;
    bus.op_i        = op;
    bus.last_i      = last;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_o);
    end
    vectors++;
    if (bus.result_o !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_result: got %h want 0", bus.result_o);
    end
    vectors++;
    if ({bus.cnu_o, bus.min1_o, bus.min2_o, bus.min_idx_o, bus.sign_o} !== 34'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_cnu_fields: got cnu=%b m1=%h m2=%h idx=%h s=%b want all 0",
               bus.cnu_o, bus.min1_o, bus.min2_o, bus.min_idx_o, bus.sign_o);
    end
    vectors++;
    if (bus.ready_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", bus.ready_o);
    end
  endtask

  task automatic test_add_sub();
    send(OP_ADD, 1'b0, pk(100, -100, 5, 127), pk(100, -100, -5, 1));
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.cnu_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL add_valid: got v=%b c=%b want v=1 c=0", bus.valid_o, bus.cnu_o);
    end
    vectors++;
    if (bus.result_o !== pk(127, -128, 0, 127)) begin
      miscompares++; $display("[TB] FAIL add_sat: got %h want %h", bus.result_o, pk(127, -128, 0, 127));
    end
    idle();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL add_valid_drop: got %b want 0", bus.valid_o);
    end
    send(OP_SUB, 1'b0, pk(-100, 100, 5, -128), pk(100, -100, 5, 1));
    vectors++;
    if (bus.result_o !== pk(-128, 127, 0, -128)) begin
      miscompares++; $display("[TB] FAIL sub_sat: got %h want %h", bus.result_o, pk(-128, 127, 0, -128));
    end
  endtask

  task automatic test_max_min_rsvd();
    send(OP_MAX, 1'b0, pk(3, -4, -128, 127), pk(-3, 5, -127, 127));
    vectors++;
    if (bus.result_o !== pk(3, 5, -127, 127)) begin
      miscompares++; $display("[TB] FAIL max: got %h want %h", bus.result_o, pk(3, 5, -127, 127));
    end
    send(OP_MIN, 1'b0, pk(3, -4, -128, 127), pk(-3, 5, -127, 127));
    vectors++;
    if (bus.result_o !== pk(-3, -4, -128, 127)) begin
      miscompares++; $display("[TB] FAIL min: got %h want %h", bus.result_o, pk(-3, -4, -128, 127));
    end
    send(OP_RSVD, 1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8));
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.result_o !== 32'h0 || bus.cnu_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reserved: got v=%b r=%h c=%b want v=1 r=0 c=0", bus.valid_o, bus.result_o, bus.cnu_o);
    end
  endtask

  task automatic test_scale_abs();
    send(OP_SCALE, 1'b0, pk(-128, 127, 4, -5), pk(9, 9, 9, 9));
    vectors++;
    if (bus.result_o !== pk(-96, 96, 3, -3)) begin
      miscompares++; $display("[TB] FAIL scale: got %h want %h", bus.result_o, pk(-96, 96, 3, -3));
    end
    send(OP_ABS, 1'b0, pk(-128, -3, 0, 7), pk(9, 9, 9, 9));
    vectors++;
    if (bus.result_o !== pk(127, 3, 0, 7)) begin
      miscompares++; $display("[TB] FAIL abs: got %h want %h", bus.result_o, pk(127, 3, 0, 7));
    end
    idle();
  endtask

  task automatic test_cnu();
    send(OP_CNU, 1'b0, pk(9, -3, 7, 5), 32'h0);
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL cnu_nonlast_quiet: got valid %b want 0", bus.valid_o);
    end
    send(OP_CNU, 1'b1, pk(4, -2, 8, 3), 32'h0);
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.cnu_o !== 1'b1 || bus.result_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL cnu_beat: got v=%b c=%b r=%h want v=1 c=1 r=0", bus.valid_o, bus.cnu_o, bus.result_o);
    end
    vectors++;
    if (bus.min1_o !== 8'd2 || bus.min2_o !== 8'd3 || bus.min_idx_o !== 16'd5 || bus.sign_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cnu_two_beat: got m1=%0d m2=%0d idx=%0d s=%b want m1=2 m2=3 idx=5 s=0",
               bus.min1_o, bus.min2_o, bus.min_idx_o, bus.sign_o);
    end
    idle();
  endtask

  task automatic test_back_to_back_stall();
    bus.ready_i = 1'b0;
    send(OP_ADD, 1'b0, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    bus.valid_i     = 1'b1;
    bus.op_i        = OP_SUB;
    bus.operand_a_i = pk(10, 10, 10, 10);
    bus.operand_b_i = pk(1, 2, 3, 4);
    for (int i = 0; i < 3; i++) begin
      idle();
      vectors++;
      if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.result_o !== pk(2, 3, 4, 5)) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got rdy=%b v=%b r=%h want rdy=0 v=1 r=%h",
                 i, bus.ready_o, bus.valid_o, bus.result_o, pk(2, 3, 4, 5));
      end
    end
    bus.ready_i = 1'b1;
    #1;
    vectors++;
    if (bus.ready_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL stall_release_ready: got %b want 1", bus.ready_o);
    end
    idle();
    bus.valid_i = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.result_o !== pk(9, 8, 7, 6)) begin
      miscompares++;
      $display("[TB] FAIL stall_second_beat: got v=%b r=%h want v=1 r=%h", bus.valid_o, bus.result_o, pk(9, 8, 7, 6));
    end
    idle();
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall_no_duplicate: got valid %b want 0", bus.valid_o);
    end
  endtask

  task automatic test_interleave();
    send(OP_CNU, 1'b0, pk(9, -3, 7, 5), 32'h0);
    send(OP_MAX, 1'b0, pk(1, -1, 0, 0), pk(0, 0, 5, -5));
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.cnu_o !== 1'b0 || bus.result_o !== pk(1, 0, 5, 0)) begin
      miscompares++;
      $display("[TB] FAIL interleave_max: got v=%b c=%b r=%h want v=1 c=0 r=%h",
               bus.valid_o, bus.cnu_o, bus.result_o, pk(1, 0, 5, 0));
    end
    send(OP_CNU, 1'b1, pk(4, -2, 8, 3), 32'h0);
    vectors++;
    if (bus.cnu_o !== 1'b1 || bus.min1_o !== 8'd2 || bus.min2_o !== 8'd3 ||
        bus.min_idx_o !== 16'd5 || bus.sign_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL interleave_cnu: got c=%b m1=%0d m2=%0d idx=%0d s=%b want c=1 m1=2 m2=3 idx=5 s=0",
               bus.cnu_o, bus.min1_o, bus.min2_o, bus.min_idx_o, bus.sign_o);
    end
    idle();
  endtask

  task automatic test_reset_mid_cnu();
    send(OP_CNU, 1'b0, pk(9, -3, 7, 5), 32'h0);
    bus.ready_i = 1'b0;
    send(OP_ADD, 1'b0, pk(1, 1, 1, 1), pk(1, 1, 1, 1));
    rst = 1'b1;
    idle();
    rst = 1'b0;
    bus.ready_i = 1'b1;
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.result_o !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_drops_pending: got v=%b r=%h want v=0 r=0", bus.valid_o, bus.result_o);
    end
    send(OP_CNU, 1'b1, pk(6, 1, 1, -9), 32'h0);
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.cnu_o !== 1'b1 || bus.min1_o !== 8'd1 || bus.min2_o !== 8'd1 ||
        bus.min_idx_o !== 16'd1 || bus.sign_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_beat_after_reset: got v=%b c=%b m1=%0d m2=%0d idx=%0d s=%b want v=1 c=1 m1=1 m2=1 idx=1 s=1",
               bus.valid_o, bus.cnu_o, bus.min1_o, bus.min2_o, bus.min_idx_o, bus.sign_o);
    end
    idle();
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.ready_i     = 1'b1;
    bus.op_i        = OP_MAX;
    bus.last_i      = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    $display("[TB] ldpc_simd_alu directed tests starting");
    test_reset();
    test_add_sub();
    test_max_min_rsvd();
    test_scale_abs();
    test_cnu();
    test_back_to_back_stall();
    test_interleave();
    test_reset_mid_cnu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
